// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM state encoding
// and the digit constants used by the reverse double-dabble step.
package bcd_to_binary_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest legal value of one BCD digit.
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    // After a right shift, a digit >= 8 carried a 10 (0b1010 >> 1 = 5, plus
    // the 8 dropped in from the next digit) and must be reduced by 3.
    localparam logic [3:0] ADJ_THRESHOLD = 4'd8;
    localparam logic [3:0] ADJ_AMOUNT    = 4'd3;

endpackage

// File: rtl/bcd_to_binary_sub3.sv
// Per-digit correction cell for reverse double-dabble: subtract 3 from a
// digit that is 8 or more. Counterpart of the add3 cell in the display path.
module bcd_to_binary_sub3
    import bcd_to_binary_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= ADJ_THRESHOLD) ? (digit_in - ADJ_AMOUNT) : digit_in;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter. One result bit per clock: the packed
// BCD digits and the binary accumulator form one long register that is
// shifted right, then every digit is corrected by the sub3 cell.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int NDIGITS = 2,
    parameter int BIN_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*NDIGITS-1:0] bcd_in,
    output logic [BIN_W-1:0]     bin_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int BCD_W = 4 * NDIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt;

    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BIN_W-1:0]   bin_shift;
    logic [NDIGITS-1:0] digit_ok;
    logic               in_valid;

    // Right shift of the combined {bcd_reg, bin_reg} register.
    assign bcd_shift = {1'b0, bcd_reg[BCD_W-1:1]};
    assign bin_shift = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    // Input digit validation and per-digit post-shift correction.
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
        assign digit_ok[gi] = (bcd_in[4*gi +: 4] <= BCD_MAX_DIGIT);

        bcd_to_binary_sub3 u_sub3 (
            .digit_in  (bcd_shift[4*gi +: 4]),
            .digit_out (bcd_adj[4*gi +: 4])
        );
    end

    assign in_valid = &digit_ok;

    // Control FSM with datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bin_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (in_valid) begin
                            bcd_reg <= bcd_in;
                            bin_reg <= '0;
                            cnt     <= '0;
                            busy    <= 1'b1;
                            state   <= SHIFT;
                        end else begin
                            // Rejected request: result register left untouched.
                            err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_adj;
                    bin_reg <= bin_shift;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        // Last shift: publish the freshly shifted accumulator.
                        bin_out <= bin_shift;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed handshake scenarios,
// exhaustive 00..99 with a round-trip back to digits, and random inputs
// (valid and invalid) against an arithmetic reference model.
module tb_bcd_to_binary;

    localparam int NDIGITS = 2;
    localparam int BIN_W   = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [4*NDIGITS-1:0] bcd_in;
    logic [BIN_W-1:0]     bin_out;
    logic                 busy;
    logic                 done;
    logic                 err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cyc = -1;
    int last_good = 0;

    bcd_to_binary #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit digits_ok(input logic [7:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
    endfunction

    function automatic int model(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Accepted conversion; called at a negedge with the DUT in IDLE.
    // Returns at the negedge in the first IDLE cycle after the done pulse.
    task automatic run_conv(input logic [7:0] b, input bit repulse);
        int  cycles;
        int  busy_cnt;
        bit  saw_err;
        bit  overlap;
        cycles = 0; busy_cnt = 0; saw_err = 0; overlap = 0;
        start  = 1'b1;
        bcd_in = b;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 8'($urandom);
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            if (err) saw_err = 1;
            if (repulse && cycles == 3) begin
                start  = 1'b1;
                bcd_in = 8'h11;
            end
            if (repulse && cycles == 4) start = 1'b0;
            @(negedge clk);
            cycles++;
        end
        if (busy && done) overlap = 1;
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(cycles), 32'(BIN_W));
        check("busy_cycles", 32'(busy_cnt), 32'(BIN_W));
        check("busy_with_done", 32'(overlap), 32'd0);
        check("err_during_conv", 32'({saw_err, err}), 32'd0);
        check("bin_out", 32'(bin_out), 32'(model(b)));
        done_cyc  = cyc;
        last_good = model(b);
        $display("conv bcd=%h bin_out=%h expected=%h latency=%0d", b, bin_out, model(b), cycles);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'({busy, err}), 32'd0);
        // Round trip: the binary result converted back to decimal digits.
        check("round_trip", 32'({4'(bin_out / 10), 4'(bin_out % 10)}), 32'(b));
    endtask

    // Rejected request; called at a negedge with the DUT in IDLE.
    task automatic run_err(input logic [7:0] b);
        start  = 1'b1;
        bcd_in = b;
        @(negedge clk);
        start  = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_no_busy", 32'({busy, done}), 32'd0);
        check("err_bin_hold", 32'(bin_out), 32'(last_good));
        $display("err  bcd=%h err=%b bin_out=%h expected=%h", b, err, bin_out, last_good[7:0]);
        @(negedge clk);
        check("err_one_cycle", 32'({err, busy, done}), 32'd0);
    endtask

    initial begin
        int  prev_done;
        bit  saw_done;
        logic [7:0] b;

        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (2) @(negedge clk);
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_handshake", 32'({busy, done, err}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Largest input.
        run_conv(8'h99, 1'b0);

        // Back-to-back conversions, done spacing must equal BIN_W+2.
        run_conv(8'h10, 1'b0);
        prev_done = done_cyc;
        run_conv(8'h00, 1'b0);
        check("done_spacing", 32'(done_cyc - prev_done), 32'(BIN_W + 2));
        prev_done = done_cyc;
        run_conv(8'h45, 1'b0);
        check("done_spacing", 32'(done_cyc - prev_done), 32'(BIN_W + 2));

        // Invalid digit, then an immediate valid start.
        run_err(8'h3A);
        run_conv(8'h07, 1'b0);

        // Start re-pulsed during SHIFT is ignored.
        run_conv(8'h42, 1'b1);

        // Asynchronous reset in the 4th SHIFT cycle aborts with no done.
        start  = 1'b1;
        bcd_in = 8'h77;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_was_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_bin_out", 32'(bin_out), 32'd0);
        check("abort_handshake", 32'({busy, done, err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        last_good = 0;
        $display("abort bcd=77 outputs cleared");
        run_conv(8'h77, 1'b0);

        // Exhaustive valid range.
        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                run_conv({4'(t), 4'(o)}, 1'b0);
            end
        end

        // Random bytes: valid ones convert, invalid ones are rejected.
        for (int i = 0; i < 150; i++) begin
            b = 8'($urandom);
            if (digits_ok(b)) run_conv(b, 1'($urandom_range(0, 1)));
            else              run_err(b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
